// File: rtl/sgmii_gmii_rx_framer.sv
// GMII receive framer behind the SGMII PCS: qualifies bytes with the clock enable,
// strips preamble/SFD, emits a one-cycle-per-byte stream with SOF/EOF/ERR and counts frames.
module sgmii_gmii_rx_framer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        sgmii_clk_en_i,
    input  logic [1:0]  sgmii_link_i,
    input  logic        link_up_i,
    input  logic [7:0]  gmii_rxd_i,
    input  logic        gmii_rx_dv_i,
    input  logic        gmii_rx_er_i,
    input  logic        clear_cnt_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_sof_o,
    output logic        rx_eof_o,
    output logic        rx_err_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] err_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  link_q;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic [10:0] len_q, len_d;
    logic        sticky_q, sticky_d;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q, rx_sof_q, rx_eof_q, rx_err_q;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        beat, abort, len_bad, len_full, err_now;
    logic        emit, emit_sof, emit_eof, emit_err;

    assign beat     = sgmii_clk_en_i;
    assign abort    = !link_up_i || (sgmii_link_i != link_q);
    assign len_bad  = (len_q < 11'(MIN_LEN)) || (len_q > 11'(MAX_LEN));
    // The incoming byte would be number MAX_LEN+1: the frame is oversize.
    assign len_full = (len_q == 11'(MAX_LEN));
    assign err_now  = sticky_q || gmii_rx_er_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else if (beat) begin
            case (state_q)
                S_IDLE, S_PREAMBLE: begin
                    if (!gmii_rx_dv_i)             state_d = S_IDLE;
                    else if (gmii_rxd_i == 8'h55)  state_d = S_PREAMBLE;
                    else if (gmii_rxd_i == 8'hD5)  state_d = S_DATA;
                    else                           state_d = S_DROP;
                end
                S_DATA: begin
                    if (!gmii_rx_dv_i)  state_d = S_IDLE;
                    else if (len_full)  state_d = S_DROP;
                end
                S_DROP: begin
                    if (!gmii_rx_dv_i)  state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        len_d      = len_q;
        sticky_d   = sticky_q;
        emit       = 1'b0;
        emit_sof   = (len_q == 11'd1);
        emit_eof   = 1'b0;
        emit_err   = 1'b0;
        if (abort) begin
            if (state_q == S_DATA && hold_vld_q) begin
                emit     = 1'b1;
                emit_eof = 1'b1;
                emit_err = 1'b1;
            end
            hold_vld_d = 1'b0;
        end else if (beat) begin
            if (state_q != S_DATA) begin
                if (state_d == S_DATA) begin
                    len_d      = '0;
                    hold_vld_d = 1'b0;
                    sticky_d   = 1'b0;
                end
            end else begin
                sticky_d = err_now;
                if (!gmii_rx_dv_i) begin
                    emit       = hold_vld_q;
                    emit_eof   = 1'b1;
                    emit_err   = err_now || len_bad;
                    hold_vld_d = 1'b0;
                end else if (len_full) begin
                    emit       = hold_vld_q;
                    emit_eof   = 1'b1;
                    emit_err   = 1'b1;
                    hold_vld_d = 1'b0;
                end else begin
                    emit       = hold_vld_q;
                    hold_d     = gmii_rxd_i;
                    hold_vld_d = 1'b1;
                    len_d      = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
                end
            end
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (clear_cnt_i) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end else if (emit && emit_eof) begin
            if (!emit_err && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
            if (emit_err && err_cnt_q != 16'hFFFF)    err_cnt_d   = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            link_q      <= 2'b00;
            hold_q      <= 8'h00;
            hold_vld_q  <= 1'b0;
            len_q       <= '0;
            sticky_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_sof_q    <= 1'b0;
            rx_eof_q    <= 1'b0;
            rx_err_q    <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            link_q      <= sgmii_link_i;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            len_q       <= len_d;
            sticky_q    <= sticky_d;
            if (emit) rx_data_q <= hold_q;
            rx_valid_q  <= emit;
            rx_sof_q    <= emit && emit_sof;
            rx_eof_q    <= emit && emit_eof;
            rx_err_q    <= emit && emit_eof && emit_err;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_sof_o    = rx_sof_q;
    assign rx_eof_o    = rx_eof_q;
    assign rx_err_o    = rx_err_q;
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_sgmii_gmii_rx_framer.sv
// Scoreboard bench for sgmii_gmii_rx_framer: stimulus pushes expected bytes,
// a negedge monitor pops and compares every RX_VALID strobe and its spacing.
module tb_sgmii_gmii_rx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sgmii_clk_en;
    logic [1:0]  sgmii_link;
    logic        link_up;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic        clear_cnt;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_err;
    logic [15:0] frame_cnt, err_cnt;

    always #4 clk = ~clk;

    sgmii_gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .sgmii_clk_en_i (sgmii_clk_en),
        .sgmii_link_i   (sgmii_link),
        .link_up_i      (link_up),
        .gmii_rxd_i     (gmii_rxd),
        .gmii_rx_dv_i   (gmii_rx_dv),
        .gmii_rx_er_i   (gmii_rx_er),
        .clear_cnt_i    (clear_cnt),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_sof_o       (rx_sof),
        .rx_eof_o       (rx_eof),
        .rx_err_o       (rx_err),
        .frame_cnt_o    (frame_cnt),
        .err_cnt_o      (err_cnt)
    );

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       err;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_strobe = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual data=0x%0h sof=%0b eof=%0b err=%0b required=no strobe",
                         rx_data, rx_sof, rx_eof, rx_err);
            end else begin
                mon_e = exp_q.pop_front();
                $display("strobe data=0x%02h sof=%0b eof=%0b err=%0b cycle=%0d",
                         rx_data, rx_sof, rx_eof, rx_err, cyc);
                check("strobe{data,sof,eof,err}", {20'd0, rx_data, rx_sof, rx_eof, rx_err, 1'b0},
                      {20'd0, mon_e.d, mon_e.sof, mon_e.eof, mon_e.err, 1'b0});
                if (mon_e.gap != 0) check("strobe_gap", cyc - last_strobe, mon_e.gap);
            end
            last_strobe = cyc;
        end else if (rst_n) begin
            check("idle_markers", {29'd0, rx_sof, rx_eof, rx_err}, 32'd0);
        end
    end

    task automatic beat(input int p, input logic dv, input logic [7:0] d, input logic er);
        sgmii_clk_en = 1'b1;
        gmii_rx_dv   = dv;
        gmii_rxd     = d;
        gmii_rx_er   = er;
        @(posedge clk); #1;
        if (p > 1) begin
            sgmii_clk_en = 1'b0;
            repeat (p - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic idle(input int n);
        gmii_rx_dv = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_pulse();
        clear_cnt = 1'b1;
        @(posedge clk); #1;
        clear_cnt = 1'b0;
    endtask

    task automatic push_bytes(input int n, input int p, input bit bad);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d   = i[7:0];
            e.sof = (i == 0);
            e.eof = (i == n - 1);
            e.err = (i == n - 1) && bad;
            e.gap = (i == 0) ? 0 : p;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_head(input int p, input int n);
        for (int i = 0; i < 7; i++) beat(p, 1'b1, 8'h55, 1'b0);
        beat(p, 1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < n; i++) beat(p, 1'b1, i[7:0], 1'b0);
    endtask

    task automatic send_frame(input int p, input int n, input int er_idx, input bit clr);
        bit bad;
        bad = (er_idx >= 0) || (n < 64) || (n > 1522);
        push_bytes((n > 1522) ? 1522 : n, p, bad);
        for (int i = 0; i < 7; i++) beat(p, 1'b1, 8'h55, 1'b0);
        beat(p, 1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < n; i++) beat(p, 1'b1, i[7:0], (i == er_idx));
        clear_cnt = clr;
        beat(p, 1'b0, 8'h00, 1'b0);
        clear_cnt = 1'b0;
        for (int i = 0; i < 3; i++) beat(p, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_cnt(input string name, input logic [15:0] f, input logic [15:0] e);
        $display("%s frame_cnt=%0d err_cnt=%0d", name, frame_cnt, err_cnt);
        check({name, "_frame_cnt"}, {16'd0, frame_cnt}, {16'd0, f});
        check({name, "_err_cnt"}, {16'd0, err_cnt}, {16'd0, e});
    endtask

    initial begin
        rst_n        = 1'b0;
        sgmii_clk_en = 1'b1;
        sgmii_link   = 2'b10;
        link_up      = 1'b1;
        gmii_rxd     = 8'h00;
        gmii_rx_dv   = 1'b0;
        gmii_rx_er   = 1'b0;
        clear_cnt    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_markers", {29'd0, rx_sof, rx_eof, rx_err}, 32'd0);
        check_cnt("rst", 16'd0, 16'd0);
        rst_n = 1'b1;
        idle(3);

        // 1G good 64-byte frame
        send_frame(1, 64, -1, 1'b0);
        check_cnt("good_1g", 16'd1, 16'd0);

        // 100M, RX_ER on byte 10
        clear_pulse();
        sgmii_link = 2'b01;
        idle(4);
        send_frame(10, 64, 10, 1'b0);
        check_cnt("rxer_100m", 16'd0, 16'd1);

        // 1G undersize and oversize
        sgmii_link = 2'b10;
        idle(4);
        clear_pulse();
        send_frame(1, 63, -1, 1'b0);
        check_cnt("short_63", 16'd0, 16'd1);
        clear_pulse();
        send_frame(1, 1523, -1, 1'b0);
        check_cnt("long_1523", 16'd0, 16'd1);

        // 10M link drop after 20 data bytes, then a good frame
        sgmii_link = 2'b00;
        idle(4);
        clear_pulse();
        push_bytes(20, 100, 1'b1);
        send_head(100, 20);
        link_up = 1'b0;
        idle(3);
        link_up = 1'b1;
        idle(3);
        check_cnt("linkdrop_10m", 16'd0, 16'd1);
        send_frame(100, 64, -1, 1'b0);
        check_cnt("after_drop_10m", 16'd1, 16'd1);

        // junk frame 0x55 0x12 ... then speed change mid-frame
        sgmii_link = 2'b10;
        idle(4);
        clear_pulse();
        beat(1, 1'b1, 8'h55, 1'b0);
        beat(1, 1'b1, 8'h12, 1'b0);
        beat(1, 1'b1, 8'hD5, 1'b0);
        beat(1, 1'b1, 8'h34, 1'b0);
        beat(1, 1'b0, 8'h00, 1'b0);
        idle(3);
        check_cnt("junk", 16'd0, 16'd0);
        push_bytes(20, 1, 1'b1);
        send_head(1, 20);
        sgmii_link = 2'b01;
        @(posedge clk); #1;
        gmii_rx_dv = 1'b0;
        idle(4);
        check_cnt("speed_change", 16'd0, 16'd1);

        // saturation and clear coincident with EOF
        sgmii_link = 2'b10;
        idle(4);
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_cnt_q;
        idle(2);
        send_frame(1, 64, -1, 1'b0);
        check_cnt("saturate", 16'hFFFF, 16'd1);
        send_frame(1, 64, -1, 1'b1);
        check_cnt("clear_at_eof", 16'd0, 16'd0);

        idle(10);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
